// File: rtl/i2c_target_regfile.sv
// I2C target with a DEPTH-byte register file: pointer-byte writes, auto-incrementing reads,
// and a local host read port plus a write-notify strobe for every byte written from the bus.
module i2c_target_regfile #(
    parameter logic [6:0]  DEV_ADDR = 7'b1101001,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AW       = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          scl_in,
    input  logic          sda_in,
    output logic          sda_oe,
    output logic          busy,
    output logic          wr_valid,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    input  logic [AW-1:0] host_addr,
    output logic [7:0]    host_rdata
);

    localparam int unsigned CW = 4;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RACK,
        IGNORE
    } state_t;

    state_t        state, state_nxt;
    logic [1:0]    scl_sync, sda_sync;
    logic          scl_d, sda_d;
    logic          scl_s, sda_s;
    logic          start_ev, stop_ev, rise_ev, fall_ev;
    logic [CW-1:0] bit_cnt, bit_cnt_nxt;
    logic [7:0]    shreg, shreg_nxt;
    logic [AW-1:0] ptr, ptr_nxt;
    logic          rw, rw_nxt;
    logic          mnack, mnack_nxt;
    logic          sda_oe_nxt, busy_nxt, wr_valid_nxt;
    logic [AW-1:0] wr_addr_nxt;
    logic [7:0]    wr_data_nxt;
    logic          reg_we;
    logic [7:0]    rx_byte;
    logic [7:0]    rd_byte;
    logic [7:0]    regs [DEPTH];

    // Two-stage synchronizers plus a previous-value stage for edge detection; idle bus is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl_in};
            sda_sync <= {sda_sync[0], sda_in};
            scl_d    <= scl_sync[1];
            sda_d    <= sda_sync[1];
        end
    end

    assign scl_s    = scl_sync[1];
    assign sda_s    = sda_sync[1];
    assign start_ev = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_ev  = scl_s & scl_d & ~sda_d & sda_s;
    assign rise_ev  = scl_s & ~scl_d;
    assign fall_ev  = ~scl_s & scl_d;

    assign rx_byte    = {shreg[6:0], sda_s};
    assign rd_byte    = regs[ptr];
    assign host_rdata = regs[host_addr];

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            shreg    <= '0;
            ptr      <= '0;
            rw       <= 1'b0;
            mnack    <= 1'b0;
            sda_oe   <= 1'b0;
            busy     <= 1'b0;
            wr_valid <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            state    <= state_nxt;
            bit_cnt  <= bit_cnt_nxt;
            shreg    <= shreg_nxt;
            ptr      <= ptr_nxt;
            rw       <= rw_nxt;
            mnack    <= mnack_nxt;
            sda_oe   <= sda_oe_nxt;
            busy     <= busy_nxt;
            wr_valid <= wr_valid_nxt;
            wr_addr  <= wr_addr_nxt;
            wr_data  <= wr_data_nxt;
        end
    end

    // Register file; the bus write lands on the clock after the 8th data bit is sampled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                regs[i] <= '0;
            end
        end else if (reg_we) begin
            regs[ptr] <= rx_byte;
        end
    end

    // Next-state and output logic; START/STOP take priority over SCL edges.
    always_comb begin
        state_nxt    = state;
        bit_cnt_nxt  = bit_cnt;
        shreg_nxt    = shreg;
        ptr_nxt      = ptr;
        rw_nxt       = rw;
        mnack_nxt    = mnack;
        sda_oe_nxt   = sda_oe;
        busy_nxt     = busy;
        wr_valid_nxt = 1'b0;
        wr_addr_nxt  = wr_addr;
        wr_data_nxt  = wr_data;
        reg_we       = 1'b0;

        if (start_ev) begin
            state_nxt   = ADDR;
            bit_cnt_nxt = '0;
            sda_oe_nxt  = 1'b0;
            busy_nxt    = 1'b0;
        end else if (stop_ev) begin
            state_nxt   = IDLE;
            bit_cnt_nxt = '0;
            sda_oe_nxt  = 1'b0;
            busy_nxt    = 1'b0;
        end else begin
            unique case (state)
                ADDR: begin
                    if (rise_ev) begin
                        shreg_nxt   = rx_byte;
                        bit_cnt_nxt = CW'(bit_cnt + CW'(1));
                    end else if (fall_ev && bit_cnt == CW'(8)) begin
                        if (shreg[7:1] == DEV_ADDR) begin
                            rw_nxt     = shreg[0];
                            sda_oe_nxt = 1'b1;
                            busy_nxt   = 1'b1;
                            state_nxt  = ADDR_ACK;
                        end else begin
                            state_nxt = IGNORE;
                        end
                    end
                end
                // Ack slots are entered on a FALL, so the next FALL ends the slot.
                ADDR_ACK: begin
                    if (fall_ev) begin
                        bit_cnt_nxt = '0;
                        if (rw) begin
                            shreg_nxt  = rd_byte;
                            ptr_nxt    = ptr + AW'(1);
                            sda_oe_nxt = ~rd_byte[7];
                            state_nxt  = RDATA;
                        end else begin
                            sda_oe_nxt = 1'b0;
                            state_nxt  = PTR;
                        end
                    end
                end
                PTR: begin
                    if (rise_ev) begin
                        shreg_nxt   = rx_byte;
                        bit_cnt_nxt = CW'(bit_cnt + CW'(1));
                    end else if (fall_ev && bit_cnt == CW'(8)) begin
                        ptr_nxt    = shreg[AW-1:0];
                        sda_oe_nxt = 1'b1;
                        state_nxt  = PTR_ACK;
                    end
                end
                PTR_ACK, WDATA_ACK: begin
                    if (fall_ev) begin
                        sda_oe_nxt  = 1'b0;
                        bit_cnt_nxt = '0;
                        state_nxt   = WDATA;
                    end
                end
                WDATA: begin
                    if (rise_ev) begin
                        shreg_nxt   = rx_byte;
                        bit_cnt_nxt = CW'(bit_cnt + CW'(1));
                        if (bit_cnt == CW'(7)) begin
                            reg_we       = 1'b1;
                            wr_valid_nxt = 1'b1;
                            wr_addr_nxt  = ptr;
                            wr_data_nxt  = rx_byte;
                            ptr_nxt      = ptr + AW'(1);
                        end
                    end else if (fall_ev && bit_cnt == CW'(8)) begin
                        sda_oe_nxt = 1'b1;
                        state_nxt  = WDATA_ACK;
                    end
                end
                RDATA: begin
                    if (rise_ev) begin
                        bit_cnt_nxt = CW'(bit_cnt + CW'(1));
                    end else if (fall_ev) begin
                        if (bit_cnt == CW'(8)) begin
                            sda_oe_nxt = 1'b0;
                            state_nxt  = RACK;
                        end else begin
                            shreg_nxt  = {shreg[6:0], 1'b0};
                            sda_oe_nxt = ~shreg[6];
                        end
                    end
                end
                RACK: begin
                    if (rise_ev) begin
                        mnack_nxt = sda_s;
                    end else if (fall_ev) begin
                        bit_cnt_nxt = '0;
                        if (mnack) begin
                            sda_oe_nxt = 1'b0;
                            state_nxt  = IGNORE;
                        end else begin
                            shreg_nxt  = rd_byte;
                            ptr_nxt    = ptr + AW'(1);
                            sda_oe_nxt = ~rd_byte[7];
                            state_nxt  = RDATA;
                        end
                    end
                end
                IDLE, IGNORE: begin
                    sda_oe_nxt = 1'b0;
                end
                default: begin
                    state_nxt  = IDLE;
                    sda_oe_nxt = 1'b0;
                    busy_nxt   = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Directed bench: a bit-banged I2C master drives the target and checks ACKs, read data,
// write strobes and the host read port against hand-computed values.
module tb_i2c_target_regfile;

    localparam int unsigned AW = 4;
    localparam int unsigned Q  = 20;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          scl = 1'b1;
    logic          m_low = 1'b0;
    logic          sda_bus;
    logic          sda_oe;
    logic          busy;
    logic          wr_valid;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic [AW-1:0] host_addr = '0;
    logic [7:0]    host_rdata;

    int unsigned   n_chk = 0;
    int unsigned   n_err = 0;
    int unsigned   wv_cnt = 0;
    int unsigned   oe_cnt = 0;
    logic [11:0]   wv_log [64];

    assign sda_bus = ~(m_low | sda_oe);

    always #5 clk = ~clk;

    i2c_target_regfile dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .scl_in     (scl),
        .sda_in     (sda_bus),
        .sda_oe     (sda_oe),
        .busy       (busy),
        .wr_valid   (wr_valid),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .host_addr  (host_addr),
        .host_rdata (host_rdata)
    );

    // Record every write strobe and count cycles with SDA driven by the target.
    always @(negedge clk) begin
        if (wr_valid) begin
            wv_log[wv_cnt[5:0]] <= {wr_addr, wr_data};
            wv_cnt <= wv_cnt + 1;
        end
        if (sda_oe) oe_cnt <= oe_cnt + 1;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_low = 1'b0; wait_q();
        scl = 1'b1;   wait_q();
        m_low = 1'b1; wait_q();
        scl = 1'b0;   wait_q();
    endtask

    task automatic i2c_stop();
        m_low = 1'b1; wait_q();
        scl = 1'b1;   wait_q();
        m_low = 1'b0; wait_q();
    endtask

    task automatic write_bit(input logic b);
        m_low = ~b; wait_q();
        scl = 1'b1; wait_q();
        scl = 1'b0; wait_q();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        m_low = 1'b0; wait_q();
        scl = 1'b1;   wait_q();
        ack = sda_bus;
        scl = 1'b0;   wait_q();
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        m_low = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            wait_q();
            scl = 1'b1; wait_q();
            d[i] = sda_bus;
            scl = 1'b0;
        end
        wait_q();
        m_low = ~nack; wait_q();
        scl = 1'b1;    wait_q();
        scl = 1'b0;    wait_q();
        m_low = 1'b0;
    endtask

    task automatic wr_chk(input string tag, input logic [7:0] b, input logic exp_ack);
        logic a;
        write_byte(b, a);
        chk(tag, 32'(a), 32'(exp_ack));
    endtask

    task automatic rd_chk(input string tag, input logic nack, input logic [7:0] exp);
        logic [7:0] d;
        read_byte(nack, d);
        chk(tag, 32'(d), 32'(exp));
    endtask

    task automatic host_chk(input string tag, input logic [AW-1:0] a, input logic [7:0] exp);
        host_addr = a;
        #1;
        chk(tag, 32'(host_rdata), 32'(exp));
    endtask

    initial begin
        int unsigned wv_base;
        int unsigned oe_base;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_sda_oe",   32'(sda_oe),     32'h0);
        chk("rst_busy",     32'(busy),       32'h0);
        chk("rst_wr_valid", 32'(wr_valid),   32'h0);
        chk("rst_wr_addr",  32'(wr_addr),    32'h0);
        chk("rst_wr_data",  32'(wr_data),    32'h0);
        chk("rst_host_rd",  32'(host_rdata), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_q();

        // Plain write: pointer 3, data A5, 5A.
        wv_base = wv_cnt;
        i2c_start();
        wr_chk("t1_ack_addr", 8'hD2, 1'b0);
        chk("t1_busy", 32'(busy), 32'h1);
        wr_chk("t1_ack_ptr", 8'h03, 1'b0);
        wr_chk("t1_ack_d0",  8'hA5, 1'b0);
        wr_chk("t1_ack_d1",  8'h5A, 1'b0);
        i2c_stop();
        chk("t1_busy_stop", 32'(busy), 32'h0);
        chk("t1_wv_count", wv_cnt - wv_base, 32'd2);
        chk("t1_wv0", 32'(wv_log[wv_base[5:0]]), 32'h3A5);
        chk("t1_wv1", 32'(wv_log[6'(wv_base + 1)]), 32'h45A);
        host_chk("t1_reg3", 4'd3, 8'hA5);
        host_chk("t1_reg4", 4'd4, 8'h5A);

        // Seed reg 5 so the read pointer position becomes observable.
        i2c_start();
        wr_chk("t2_seed_addr", 8'hD2, 1'b0);
        wr_chk("t2_seed_ptr",  8'h05, 1'b0);
        wr_chk("t2_seed_d",    8'h77, 1'b0);
        i2c_stop();

        // Pointer write, repeated start, two-byte read.
        i2c_start();
        wr_chk("t2_ack_addr", 8'hD2, 1'b0);
        wr_chk("t2_ack_ptr",  8'h03, 1'b0);
        i2c_start();
        wr_chk("t2_ack_raddr", 8'hD3, 1'b0);
        rd_chk("t2_rd0", 1'b0, 8'hA5);
        rd_chk("t2_rd1", 1'b1, 8'h5A);
        chk("t2_sda_released", 32'(sda_oe), 32'h0);
        i2c_stop();
        i2c_start();
        wr_chk("t2_ack_raddr2", 8'hD3, 1'b0);
        rd_chk("t2_rd_ptr5", 1'b1, 8'h77);
        i2c_stop();

        // Wrong address: target must stay silent.
        wv_base = wv_cnt;
        oe_base = oe_cnt;
        i2c_start();
        wr_chk("t3_nack_addr", 8'hA0, 1'b1);
        wr_chk("t3_nack_d0",   8'h11, 1'b1);
        wr_chk("t3_nack_d1",   8'h22, 1'b1);
        i2c_stop();
        chk("t3_oe_cycles", oe_cnt - oe_base, 32'd0);
        chk("t3_wv_count",  wv_cnt - wv_base, 32'd0);

        // Pointer wrap and upper pointer bits ignored.
        wv_base = wv_cnt;
        i2c_start();
        wr_chk("t4_ack_addr", 8'hD2, 1'b0);
        wr_chk("t4_ack_ptr",  8'h0F, 1'b0);
        wr_chk("t4_ack_d0",   8'h11, 1'b0);
        wr_chk("t4_ack_d1",   8'h22, 1'b0);
        i2c_stop();
        chk("t4_wv0", 32'(wv_log[wv_base[5:0]]), 32'hF11);
        chk("t4_wv1", 32'(wv_log[6'(wv_base + 1)]), 32'h022);
        host_chk("t4_reg15", 4'd15, 8'h11);
        host_chk("t4_reg0",  4'd0,  8'h22);
        wv_base = wv_cnt;
        i2c_start();
        wr_chk("t4_ack_addr2", 8'hD2, 1'b0);
        wr_chk("t4_ack_ptr1f", 8'h1F, 1'b0);
        wr_chk("t4_ack_d2",    8'h33, 1'b0);
        i2c_stop();
        chk("t4_wv_1f", 32'(wv_log[wv_base[5:0]]), 32'hF33);
        host_chk("t4_reg15_b", 4'd15, 8'h33);

        // Reset while the target is driving a 0 data bit (A5 bit6).
        i2c_start();
        wr_chk("t5_ack_addr", 8'hD2, 1'b0);
        wr_chk("t5_ack_ptr",  8'h03, 1'b0);
        i2c_start();
        wr_chk("t5_ack_raddr", 8'hD3, 1'b0);
        wait_q();
        scl = 1'b1; wait_q();
        chk("t5_bit7", 32'(sda_bus), 32'h1);
        scl = 1'b0;
        repeat (6) @(negedge clk);
        chk("t5_oe_before_rst", 32'(sda_oe), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("t5_oe_after_rst", 32'(sda_oe), 32'h0);
        chk("t5_busy_rst",     32'(busy),   32'h0);
        for (int i = 0; i < 16; i++) host_chk("t5_reg_clr", AW'(i), 8'h00);
        m_low = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        wait_q();
        wv_base = wv_cnt;
        i2c_start();
        wr_chk("t5_ack_addr2", 8'hD2, 1'b0);
        wr_chk("t5_ack_ptr2",  8'h02, 1'b0);
        wr_chk("t5_ack_d",     8'h3C, 1'b0);
        i2c_stop();
        chk("t5_wv", 32'(wv_log[wv_base[5:0]]), 32'h23C);
        host_chk("t5_reg2", 4'd2, 8'h3C);

        // STOP in the middle of a data byte.
        i2c_start();
        wr_chk("t6_ack_addr", 8'hD2, 1'b0);
        wr_chk("t6_ack_ptr",  8'h07, 1'b0);
        wr_chk("t6_ack_d",    8'h99, 1'b0);
        i2c_stop();
        wv_base = wv_cnt;
        i2c_start();
        wr_chk("t6_ack_addr2", 8'hD2, 1'b0);
        wr_chk("t6_ack_ptr2",  8'h07, 1'b0);
        write_bit(1'b1);
        write_bit(1'b0);
        write_bit(1'b1);
        write_bit(1'b0);
        chk("t6_busy_mid", 32'(busy), 32'h1);
        i2c_stop();
        chk("t6_wv_count", wv_cnt - wv_base, 32'd0);
        chk("t6_busy",     32'(busy), 32'h0);
        host_chk("t6_reg7", 4'd7, 8'h99);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
